mult_share_sched: RTL and testbench
===================================

// Module: mult_share_sched
// PURPOSE
//  Shares one pipelined 8x8 unsigned add-tree multiplier between N_REQ requesters.
//  Arbitrates round-robin, issues one operand pair per cycle, and tracks in-flight ops by tag.
//  Routes each 16-bit product back to the requester that issued it, through a per-requester result slot.
//  Sits between requesting datapath blocks and a single multiplier instance.
// PARAMETERS
//  N_REQ   4   number of requesters (2..8)
//  LAT     1   multiplier latency in clk edges, from operand capture to valid mul_out (1..4)
// PORTS
//  clk        in   1         system clock; all state updates on posedge
//  rst_n      in   1         asynchronous, active-low reset
//  en         in   1         1 = new issues allowed; 0 = no issue, in-flight ops still complete
//  req_valid  in   N_REQ     per-requester operand valid
//  req_a      in   N_REQ*8   operand a, requester i at [8i+7:8i]
//  req_b      in   N_REQ*8   operand b, requester i at [8i+7:8i]
//  req_ready  out  N_REQ     one-hot grant; operands accepted when valid&ready
//  mul_a      out  8         operand a to multiplier
//  mul_b      out  8         operand b to multiplier
//  mul_out    in   16        product from multiplier
//  rsp_valid  out  N_REQ     per-requester result valid
//  rsp_data   out  N_REQ*16  per-requester result, requester i at [16i+15:16i]
//  rsp_ready  in   N_REQ     requester consumes result when rsp_valid&rsp_ready
//  busy       out  1         any tag in flight OR any rsp_valid set
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - rr_ptr=0; tag pipe cleared; inflight=0; rsp_valid=0; rsp_data=0.
//   - busy=0; req_ready=0 while rst_n low.
//   - In-flight ops are discarded and never surface after reset release.
//  Eligibility: requester i is eligible when en & req_valid[i] & ~inflight[i] & ~rsp_valid[i].
//   - Registered state only: a slot freed this cycle is not eligible until the next cycle.
//  Arbitration (combinational):
//   - Winner g = first eligible index scanning rr_ptr, rr_ptr+1, ... mod N_REQ.
//   - req_ready = onehot(g), or 0 if none eligible.
//   - mul_a/mul_b = req_a/req_b of g; 0 when no grant.
//  Issue (posedge, grant present):
//   - rr_ptr <= (g+1) mod N_REQ; inflight[g] <= 1.
//   - tag pipe stage0 <= {valid=1, id=g}.
//   - No grant: stage0 valid <= 0; rr_ptr unchanged.
//  Tag pipe:
//   - LAT-deep shift register of {valid, id}, advancing every cycle.
//   - Never stalls: result slot is reserved at issue, so a capture always has a free slot.
//  Capture (posedge, last tag stage valid with id k):
//   - rsp_data[k] <= mul_out; rsp_valid[k] <= 1; inflight[k] <= 0.
//   - Operands accepted at edge t produce rsp_valid at edge t+LAT.
//  Response:
//   - rsp_valid[k] and rsp_data[k] are held stable until rsp_valid[k] & rsp_ready[k], then rsp_valid[k] clears.
//   - rsp_data keeps its last value after clearing.
//  Ordering and throughput:
//   - At most one op outstanding per requester.
//   - Distinct requesters can issue back-to-back, one per cycle.
//  Arithmetic: unsigned 8x8 -> full 16-bit product; no truncation or saturation in this block.
//  en=0: req_ready=0 immediately (same cycle); tags drain normally; busy falls once all slots are consumed.
// TESTING
//  1. req0 a=12,b=13, rsp_ready0=1 -> req_ready[0] in the same cycle; rsp_valid[0] LAT edges later, rsp_data0=156.
//  2. All 4 valid continuously, a=b=255, all rsp_ready=1 -> grants 0,1,2,3,0,...; every result 16'hFE01.
//  3. rsp_ready[2]=0 -> requester 2 not re-granted; data2 held stable; requesters 0,1,3 keep rotating.
//  4. Only reqs 1 and 3 valid, LAT=1 -> grant order 1,3,1,3; no cycle is lost to skipped indices.
//  5. en 1->0 with 2 ops in flight -> req_ready=0 that cycle; both results arrive; busy=0 after both are consumed.
//  6. rst_n low mid-flight -> rsp_valid=0 asynchronously; after release there are no stale results and rr_ptr=0.

Source files
------------

// File: rtl/mult_share_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : mult_share_sched_if
//  Description : Bundle of requester, multiplier and response signals for the
//                shared-multiplier scheduler.
//                master = requesters + multiplier side
//                slave  = scheduler side
//  Revision    : 1.0 - initial release
// ============================================================================
interface mult_share_sched_if #(
    parameter int N_REQ = 4
);
    logic                  en;
    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ*8-1:0]    req_a;
    logic [N_REQ*8-1:0]    req_b;
    logic [N_REQ-1:0]      req_ready;
    logic [7:0]            mul_a;
    logic [7:0]            mul_b;
    logic [15:0]           mul_out;
    logic [N_REQ-1:0]      rsp_valid;
    logic [N_REQ*16-1:0]   rsp_data;
    logic [N_REQ-1:0]      rsp_ready;
    logic                  busy;

    modport master (
        output en, req_valid, req_a, req_b, mul_out, rsp_ready,
        input  req_ready, mul_a, mul_b, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  en, req_valid, req_a, req_b, mul_out, rsp_ready,
        output req_ready, mul_a, mul_b, rsp_valid, rsp_data, busy
    );
endinterface
`default_nettype wire

// File: rtl/mult_share_sched.sv
`default_nettype none
// ============================================================================
//  Module      : mult_share_sched
//  Description : Round-robin scheduler sharing one pipelined 8x8 multiplier
//                between N_REQ requesters. One issue per cycle; a tag pipe
//                matching the multiplier latency routes each product back to
//                a per-requester result slot reserved at issue time.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_share_sched #(
    parameter int N_REQ = 4,
    parameter int LAT   = 1
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    mult_share_sched_if.slave bus
);

    localparam int c_IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [c_IDW-1:0]  r_rr_ptr;
    logic [N_REQ-1:0]  r_inflight;
    logic [N_REQ-1:0]  r_rsp_valid;
    logic [15:0]       r_rsp_data [N_REQ];
    logic              r_tag_vld  [LAT];
    logic [c_IDW-1:0]  r_tag_id   [LAT];

    logic [N_REQ-1:0]  w_elig;
    logic              w_gnt_any;
    logic [c_IDW-1:0]  w_gnt_idx;
    logic [N_REQ-1:0]  w_gnt_oh;
    logic              w_cap_vld;
    logic [c_IDW-1:0]  w_cap_id;

    // Eligibility from registered slot state only; nothing is granted in reset
    always_comb begin
        w_elig = {N_REQ{bus.en & rst_n}} & bus.req_valid & ~r_inflight & ~r_rsp_valid;
    end

    // Round-robin search starting at the pointer, wrapping modulo N_REQ
    always_comb begin : p_arb
        int v_idx;
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        v_idx     = 0;
        for (int off = 0; off < N_REQ; off++) begin
            v_idx = int'(r_rr_ptr) + off;
            if (v_idx >= N_REQ) begin
                v_idx = v_idx - N_REQ;
            end
            if (!w_gnt_any && w_elig[v_idx]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = c_IDW'(v_idx);
            end
        end
    end

    // One-hot grant and operand mux toward the multiplier (zero when idle)
    always_comb begin
        w_gnt_oh  = '0;
        bus.mul_a = 8'd0;
        bus.mul_b = 8'd0;
        if (w_gnt_any) begin
            w_gnt_oh[w_gnt_idx] = 1'b1;
            bus.mul_a = bus.req_a[{w_gnt_idx, 3'b000} +: 8];
            bus.mul_b = bus.req_b[{w_gnt_idx, 3'b000} +: 8];
        end
    end

    assign bus.req_ready = w_gnt_oh;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.busy      = (|r_inflight) | (|r_rsp_valid);
    assign w_cap_vld     = r_tag_vld[LAT-1];
    assign w_cap_id      = r_tag_id[LAT-1];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rsp
            assign bus.rsp_data[16*gi +: 16] = r_rsp_data[gi];
        end
    endgenerate

    // Round-robin pointer and tag pipe that shadows the multiplier latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
            for (int k = 0; k < LAT; k++) begin
                r_tag_vld[k] <= 1'b0;
                r_tag_id[k]  <= '0;
            end
        end else begin
            r_tag_vld[0] <= w_gnt_any;
            r_tag_id[0]  <= w_gnt_idx;
            for (int k = 1; k < LAT; k++) begin
                r_tag_vld[k] <= r_tag_vld[k-1];
                r_tag_id[k]  <= r_tag_id[k-1];
            end
            if (w_gnt_any) begin
                r_rr_ptr <= (w_gnt_idx == c_IDW'(N_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
            end
        end
    end

    // Slot bookkeeping: reserve at issue, fill at capture, free on consume.
    // A slot being captured is never the one issued or consumed in the same
    // cycle, since issue requires the slot to be empty and not in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight  <= '0;
            r_rsp_valid <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                r_rsp_data[i] <= 16'd0;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (r_rsp_valid[i] && bus.rsp_ready[i]) begin
                    r_rsp_valid[i] <= 1'b0;
                end
            end
            if (w_cap_vld) begin
                r_rsp_valid[w_cap_id] <= 1'b1;
                r_rsp_data[w_cap_id]  <= bus.mul_out;
                r_inflight[w_cap_id]  <= 1'b0;
            end
            if (w_gnt_any) begin
                r_inflight[w_gnt_idx] <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mult_share_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_share_sched
//  Description : Self-checking bench for mult_share_sched with a behavioural
//                multiplier and a per-requester transaction model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_share_sched;

    localparam int N   = 4;
    localparam int LAT = 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mult_share_sched_if #(.N_REQ(N)) bus();

    mult_share_sched #(.N_REQ(N), .LAT(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Stimulus variables
    logic         t_en;
    logic [N-1:0] t_valid;
    logic [N-1:0] t_rready;
    logic [7:0]   t_a [N];
    logic [7:0]   t_b [N];

    assign bus.en        = t_en;
    assign bus.req_valid = t_valid;
    assign bus.rsp_ready = t_rready;
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_drv
            assign bus.req_a[8*gi +: 8] = t_a[gi];
            assign bus.req_b[8*gi +: 8] = t_b[gi];
        end
    endgenerate

    // Behavioural multiplier with LAT register stages
    logic [15:0] r_mpipe [LAT];
    always @(posedge clk) begin
        r_mpipe[0] <= 16'(bus.mul_a) * 16'(bus.mul_b);
        for (int k = 1; k < LAT; k++) r_mpipe[k] <= r_mpipe[k-1];
    end
    assign bus.mul_out = r_mpipe[LAT-1];

    // Reference model: per-requester transaction state
    int          m_ptr;
    bit          m_infl [N];
    int          m_due  [N];
    logic [15:0] m_exp  [N];
    bit          m_rv   [N];
    logic [15:0] m_rd   [N];
    int          cyc;
    int          glog[$];

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0;
        cyc   = 0;
        for (int i = 0; i < N; i++) begin
            m_infl[i] = 0; m_due[i] = 0; m_exp[i] = 0; m_rv[i] = 0; m_rd[i] = 0;
        end
    endtask

    // Called at a negedge with inputs already set: check, advance one edge
    task automatic step();
        int g;
        logic [N-1:0] exp_rdy;
        logic [7:0]   ea, eb;
        bit           eb_busy;
        #1;
        g = -1;
        for (int off = 0; off < N; off++) begin
            int i;
            i = (m_ptr + off) % N;
            if (g < 0 && t_en && t_valid[i] && !m_infl[i] && !m_rv[i]) g = i;
        end
        exp_rdy = '0;
        ea = 8'd0;
        eb = 8'd0;
        if (g >= 0) begin
            exp_rdy[g] = 1'b1;
            ea = t_a[g];
            eb = t_b[g];
        end
        chk("req_ready", bus.req_ready, exp_rdy);
        chk("mul_a", bus.mul_a, ea);
        chk("mul_b", bus.mul_b, eb);
        for (int i = 0; i < N; i++) if (bus.req_ready[i]) glog.push_back(i);
        eb_busy = 0;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("rsp_valid%0d", i), bus.rsp_valid[i], m_rv[i]);
            chk($sformatf("rsp_data%0d", i), bus.rsp_data[16*i +: 16], m_rd[i]);
            if (m_rv[i] || m_infl[i]) eb_busy = 1;
        end
        chk("busy", bus.busy, eb_busy);
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            if (m_rv[i] && t_rready[i]) m_rv[i] = 0;
            if (m_infl[i] && m_due[i] == cyc) begin
                m_infl[i] = 0;
                m_rv[i]   = 1;
                m_rd[i]   = m_exp[i];
            end
        end
        if (g >= 0) begin
            m_infl[g] = 1;
            m_due[g]  = cyc + LAT;
            m_exp[g]  = 16'(t_a[g]) * 16'(t_b[g]);
            m_ptr     = (g + 1) % N;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic randomize_ops();
        for (int i = 0; i < N; i++) begin
            t_a[i] = 8'($urandom);
            t_b[i] = 8'($urandom);
        end
    endtask

    // Asynchronous reset asserted mid-cycle, released at a later negedge
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_req_ready", bus.req_ready, 0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_rsp_data", bus.rsp_data, 0);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int n, p0, cnt2, cnt_oth;
        int exp4 [4];
        exp4 = '{1, 3, 1, 3};

        // Reset with requests pending: nothing may be granted
        rst_n    = 1'b0;
        t_en     = 1'b1;
        t_valid  = '1;
        t_rready = '1;
        randomize_ops();
        model_reset();
        @(negedge clk);
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        rst_n   = 1'b1;
        t_valid = '0;

        // 1: single op 12*13, latency check
        t_a[0] = 8'd12; t_b[0] = 8'd13; t_valid = 4'b0001;
        step();
        t_valid = '0;
        n = 1;
        while (!bus.rsp_valid[0] && n < 10) begin
            step();
            n++;
        end
        chk("t1_latency", n, LAT + 1);
        chk("t1_data", bus.rsp_data[15:0], 16'd156);
        step();

        // 2: all requesters saturated with 255*255
        for (int i = 0; i < N; i++) begin t_a[i] = 8'hFF; t_b[i] = 8'hFF; end
        t_valid = '1; t_rready = '1;
        glog.delete();
        p0 = m_ptr;
        for (int k = 0; k < 12; k++) step();
        for (int k = 0; k < 8; k++)
            chk($sformatf("t2_grant%0d", k), (k < glog.size()) ? glog[k] : 99, (p0 + k) % N);

        // 3: requester 2 holds its result; others keep rotating
        t_rready = 4'b1011;
        glog.delete();
        for (int k = 0; k < 16; k++) begin randomize_ops(); step(); end
        cnt2 = 0; cnt_oth = 0;
        foreach (glog[k]) if (glog[k] == 2) cnt2++; else cnt_oth++;
        chk("t3_grants_to_2", cnt2 <= 1, 1);
        chk("t3_grants_others", cnt_oth >= 12, 1);

        // 4: only requesters 1 and 3, from pointer 0
        do_reset();
        t_valid = 4'b1010; t_rready = '1;
        glog.delete();
        for (int k = 0; k < 10; k++) begin randomize_ops(); step(); end
        for (int k = 0; k < 4; k++)
            chk($sformatf("t4_grant%0d", k), (k < glog.size()) ? glog[k] : 99, exp4[k]);

        // 5: en drops with two ops outstanding
        t_valid = '0;
        for (int k = 0; k < 4; k++) step();
        t_valid = '1; t_rready = '0; t_en = 1'b1;
        randomize_ops();
        step();
        step();
        t_en = 1'b0;
        #1;
        chk("t5_ready_en0", bus.req_ready, 0);
        for (int k = 0; k < 4; k++) step();
        chk("t5_two_results", $countones(bus.rsp_valid), 2);
        chk("t5_busy_held", bus.busy, 1);
        t_rready = '1;
        step();
        step();
        chk("t5_busy_end", bus.busy, 0);

        // 6: reset with results held and ops in flight
        t_en = 1'b1; t_valid = '1; t_rready = '0;
        for (int k = 0; k < 3; k++) begin randomize_ops(); step(); end
        do_reset();
        t_valid = '0; t_rready = '1;
        for (int k = 0; k < 4; k++) step();

        // Random traffic
        for (int k = 0; k < 300; k++) begin
            randomize_ops();
            t_valid  = N'($urandom);
            t_rready = N'($urandom);
            t_en     = ($urandom % 8) != 0;
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
